display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  - Shares one BCD-to-7-segment decoder among all digits: feeds it one 4-bit BCD

---
 rtl/display_scan_ctrl_if.sv | 22 ++
 rtl/display_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Scan controller bus: enable/load/digit data in, decoder code and anodes out.
// The master side drives the digits; the controller is the slave.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic                    frame_done;

  modport master (
    output en, load, digits_in,
    input  bcd_out, anode_n, frame_done
  );

  modport slave (
    input  en, load, digits_in,
    output bcd_out, anode_n, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-seg scan controller with blanking gap and double buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave bus
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] R_TC = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] B_TC =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam bit NOBLANK = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         staging_q, staging_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  fd_q, fd_d;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] lz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      anode_q   <= '1;
      bcd_q     <= 4'hF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      bcd_q     <= bcd_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    fd_d      = 1'b0;
    wrap      = 1'b0;

    if (bus.load) begin
      staging_d = bus.digits_in;
      pending_d = 1'b1;
    end

    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = NOBLANK ? SHOW : BLANK;
        end
        BLANK: begin
          if (cnt_q == B_TC) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == R_TC) begin
            cnt_d   = '0;
            state_d = NOBLANK ? SHOW : BLANK;
            if (idx_q == LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A load landing on the wrap edge bypasses staging.
    if (wrap) begin
      if (bus.load) begin
        shadow_d  = bus.digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic hz;
      hz = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        hz    = hz & (shadow_d[4*i +: 4] == 4'h0);
        lz[i] = hz;
      end
    end
`endif
  end

  always_comb begin
    anode_d = '1;
    bcd_d   = 4'hF;
    if (state_d == SHOW && !lz[idx_d]) begin
      anode_d[idx_d] = 1'b0;
      bcd_d          = shadow_d[{idx_d, 2'b00} +: 4];
    end
  end

  assign bus.anode_n    = anode_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: 4 digits, 4 lit, 2 blank.
// Expected outputs come from the frame timeline (24 cycles per frame).
module tb_display_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   fno = 0;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       fd;
    bit         chkp;
    logic       pend;
    string      nm;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.anode_n !== e.an) begin
        errors++;
        $display("FAIL %s anode_n: got %b want %b",
                 e.nm, bus.anode_n, e.an);
      end
      checks++;
      if (bus.bcd_out !== e.bcd) begin
        errors++;
        $display("FAIL %s bcd_out: got %h want %h",
                 e.nm, bus.bcd_out, e.bcd);
      end
      checks++;
      if (bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s frame_done: got %b want %b",
                 e.nm, bus.frame_done, e.fd);
      end
      if (e.chkp) begin
        checks++;
        if (dut.pending_q !== e.pend) begin
          errors++;
          $display("FAIL %s pending: got %b want %b",
                   e.nm, dut.pending_q, e.pend);
        end
      end
    end
  end

  // Position p in a 24-cycle frame: slot p/6, first 2 cycles blank.
  function automatic void expect_at(
    input int p, input logic [15:0] d,
    output logic [3:0] an, output logic [3:0] bcd);
    int s;
    int w;
    logic [15:0] hi;
    s   = p / 6;
    w   = p % 6;
    an  = 4'hF;
    bcd = 4'hF;
    hi  = d >> (4 * s);
    if (w >= 2 && !(LZ && s > 0 && hi == 16'h0)) begin
      an[s] = 1'b0;
      bcd   = hi[3:0];
    end
  endfunction

  task automatic tick(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
    bus.load = 1'b0;
  endtask

  task automatic idle(input string nm, input bit chkp);
    exp_t e;
    e.an   = 4'hF;
    e.bcd  = 4'hF;
    e.fd   = 1'b0;
    e.chkp = chkp;
    e.pend = 1'b0;
    e.nm   = nm;
    tick(e);
  endtask

  task automatic frame(
    input logic [15:0] d, input bit fd0, input bit pend0,
    input int load_at, input logic [15:0] lv, input int npos);
    for (int p = 0; p < npos; p++) begin
      exp_t e;
      logic [3:0] an;
      logic [3:0] bcd;
      expect_at(p, d, an, bcd);
      e.an   = an;
      e.bcd  = bcd;
      e.fd   = (p == 0) && fd0;
      e.chkp = (p == 0) || (load_at >= 0 && p == load_at + 1);
      e.pend = (p == 0) ? pend0 : 1'b1;
      e.nm   = $sformatf("f%0d.p%0d", fno, p);
      tick(e);
      if (p == load_at) begin
        bus.load      = 1'b1;
        bus.digits_in = lv;
      end
    end
    fno++;
  endtask

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0;
    idle("rst0", 1'b1);
    idle("rst1", 1'b1);
    reset = 1'b0;
    idle("idle", 1'b1);

    // first frame still shows the reset shadow
    bus.en        = 1'b1;
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    frame(16'h0000, 1'b0, 1'b1, -1, 16'h0, 24);
    // mid-frame load: current frame untouched
    frame(16'h1234, 1'b1, 1'b0, 10, 16'h5678, 24);
    // load exactly on the wrap edge
    frame(16'h5678, 1'b1, 1'b0, 23, 16'h4A09, 24);
    frame(16'h4A09, 1'b1, 1'b0, 5, 16'h0070, 24);
    // drop en during digit2 SHOW
    frame(16'h0070, 1'b1, 1'b0, -1, 16'h0, 15);
    bus.en = 1'b0;
    idle("en_off0", 1'b0);
    idle("en_off1", 1'b0);
    bus.en = 1'b1;
    frame(16'h0070, 1'b0, 1'b0, -1, 16'h0, 24);
    // reset during digit1 SHOW clears shadow
    frame(16'h0070, 1'b1, 1'b0, -1, 16'h0, 9);
    reset = 1'b1;
    idle("rst_mid", 1'b1);
    reset = 1'b0;
    frame(16'h0000, 1'b0, 1'b0, -1, 16'h0, 24);
    bus.en = 1'b0;
    idle("end", 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
